// File: rtl/encoder_pkg.sv
// Shared encodings and limits for the front-panel parameter controller.
// Also used by the display block to render defaults and bounds.
package encoder_pkg;

  typedef enum logic [1:0] {
    SEL_TB = 2'd0,
    SEL_VG = 2'd1,
    SEL_TL = 2'd2
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } press_st_e;

  localparam logic [3:0] TB_MAX  = 4'd15;
  localparam logic [3:0] TB_DEF  = 4'd8;
  localparam logic [2:0] VG_MAX  = 3'd7;
  localparam logic [2:0] VG_DEF  = 3'd3;
  localparam logic [7:0] TL_MAX  = 8'd255;
  localparam logic [7:0] TL_DEF  = 8'd128;
  localparam logic [7:0] TL_STEP = 8'd4;

  // 9-bit so that 255 + TL_STEP cannot wrap before the clamp.
  function automatic logic [8:0] sat_step(input logic [8:0] cur, input logic [8:0] step,
                                          input logic up, input logic [8:0] max_v);
    logic [8:0] r;
    if (up) r = ((cur + step) > max_v) ? max_v : (cur + step);
    else    r = (cur < step) ? 9'd0 : (cur - step);
    return r;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Push-switch 2-FF synchroniser plus level debouncer (low = pressed).
// Debounced level flips 2 + DEB_CYCLES cycles after a clean edge; no backpressure.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sw_raw_i,
  output logic pressed_o,
  output logic sync_rel_o,
  output logic sync_vld_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [1:0]    vld_q;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
      vld_q  <= 2'b00;
      db_q   <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], sw_raw_i};
      vld_q  <= {vld_q[0], 1'b1};
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_LAST) db_d = sync_q[1];
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  assign pressed_o  = ~db_q;
  assign sync_rel_o = sync_q[1];
  // The synchroniser reset value is not a real sample; flag when it has flushed.
  assign sync_vld_o = vld_q[1];

endmodule

// File: rtl/encoder_param_ctrl.sv
// Rotary-encoder parameter controller: saturating timebase/gain/trigger settings, press select/default.
// Rotation updates with 1-cycle latency and a one-cycle cfg_update strobe; no backpressure.
module encoder_param_ctrl
  import encoder_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 1_000_000,
  parameter int unsigned LONG_CYCLES = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       enc_cw,
  input  logic       enc_ccw,
  input  logic       enc_sw,
  output logic [1:0] sel,
  output logic [3:0] tb_idx,
  output logic [2:0] vg_idx,
  output logic [7:0] trig_lvl,
  output logic       cfg_update,
  output logic [1:0] cfg_addr
);

  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic          sw_pressed, sync_rel, sync_vld;
  press_st_e     state_q;
  logic [HW-1:0] hold_q;
  logic          armed_q;
  logic [1:0]    sel_q;
  logic [3:0]    tb_q;
  logic [2:0]    vg_q;
  logic [7:0]    trig_q;
  logic          upd_q;
  logic [1:0]    addr_q;

  logic          rot_up, rot_dn, rot_chg;
  logic [8:0]    cur_v, step_v, max_v, nxt_d;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw_debounce (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .sw_raw_i   (enc_sw),
    .pressed_o  (sw_pressed),
    .sync_rel_o (sync_rel),
    .sync_vld_o (sync_vld)
  );

  assign rot_up = enc_cw & ~enc_ccw;
  assign rot_dn = enc_ccw & ~enc_cw;

  always_comb begin
    cur_v  = {1'b0, trig_q};
    step_v = {1'b0, TL_STEP};
    max_v  = {1'b0, TL_MAX};
    case (sel_q)
      SEL_TB: begin cur_v = {5'd0, tb_q}; step_v = 9'd1; max_v = {5'd0, TB_MAX}; end
      SEL_VG: begin cur_v = {6'd0, vg_q}; step_v = 9'd1; max_v = {6'd0, VG_MAX}; end
      default: ;
    endcase
    nxt_d   = sat_step(cur_v, step_v, rot_up, max_v);
    rot_chg = (rot_up | rot_dn) && (state_q == ST_IDLE) && !sw_pressed && (nxt_d != cur_v);
  end

  // A press held through reset must be seen released before it may start a new press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      armed_q <= 1'b0;
      sel_q   <= SEL_TB;
      tb_q    <= TB_DEF;
      vg_q    <= VG_DEF;
      trig_q  <= TL_DEF;
      upd_q   <= 1'b0;
      addr_q  <= SEL_TB;
    end else begin
      upd_q   <= 1'b0;
      armed_q <= armed_q | (sync_vld & sync_rel & ~sw_pressed);

      if (rot_chg) begin
        upd_q  <= 1'b1;
        addr_q <= sel_q;
        case (sel_q)
          SEL_TB:  tb_q   <= nxt_d[3:0];
          SEL_VG:  vg_q   <= nxt_d[2:0];
          default: trig_q <= nxt_d[7:0];
        endcase
      end

      case (state_q)
        ST_IDLE: begin
          if (armed_q && sw_pressed) begin
            hold_q  <= '0;
            state_q <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (!sw_pressed) begin
            sel_q   <= (sel_q == SEL_TL) ? SEL_TB : (sel_q + 2'd1);
            state_q <= ST_IDLE;
          end else if (hold_q == HOLD_LAST) begin
            upd_q   <= 1'b1;
            addr_q  <= sel_q;
            case (sel_q)
              SEL_TB:  tb_q   <= TB_DEF;
              SEL_VG:  vg_q   <= VG_DEF;
              default: trig_q <= TL_DEF;
            endcase
            state_q <= ST_HELD;
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        ST_HELD: begin
          if (!sw_pressed) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sel        = sel_q;
  assign tb_idx     = tb_q;
  assign vg_idx     = vg_q;
  assign trig_lvl   = trig_q;
  assign cfg_update = upd_q;
  assign cfg_addr   = addr_q;

endmodule

// File: tb/tb_encoder_param_ctrl.sv
// Directed bench for encoder_param_ctrl with a history-based reference model.
// Debounce is modelled as "the last DEB synced samples all disagree with the level".
module tb_encoder_param_ctrl;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       enc_cw  = 1'b0;
  logic       enc_ccw = 1'b0;
  logic       enc_sw  = 1'b1;
  logic [1:0] sel;
  logic [3:0] tb_idx;
  logic [2:0] vg_idx;
  logic [7:0] trig_lvl;
  logic       cfg_update;
  logic [1:0] cfg_addr;

  int n_chk  = 0;
  int n_pass = 0;
  int upd_total = 0;
  int base = 0;
  int last_addr = 0;

  encoder_param_ctrl #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .enc_cw     (enc_cw),
    .enc_ccw    (enc_ccw),
    .enc_sw     (enc_sw),
    .sel        (sel),
    .tb_idx     (tb_idx),
    .vg_idx     (vg_idx),
    .trig_lvl   (trig_lvl),
    .cfg_update (cfg_update),
    .cfg_addr   (cfg_addr)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model ----------------
  function automatic int maxv(input int s);  return (s == 0) ? 15 : (s == 1) ? 7 : 255; endfunction
  function automatic int defv(input int s);  return (s == 0) ? 8  : (s == 1) ? 3 : 128; endfunction
  function automatic int stepv(input int s); return (s == 2) ? 4 : 1; endfunction

  logic hist[$];        // raw switch sample taken at each edge
  int   m_val[3];
  int   m_sel, m_state, m_start, m_n, m_addr;
  logic m_db, m_armed, m_upd;

  always @(posedge sys_clk or posedge sys_rst) begin : model
    int   v, st_b, sel_b;
    logic db_b, armed_b, all_diff;
    if (sys_rst) begin
      m_val[0] = 8; m_val[1] = 3; m_val[2] = 128;
      m_sel = 0; m_state = 0; m_start = 0; m_n = 0; m_addr = 0;
      m_db = 1'b1; m_armed = 1'b0; m_upd = 1'b0;
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b1);
    end else begin
      m_n++;
      hist.push_back(enc_sw);
      db_b = m_db; armed_b = m_armed; st_b = m_state; sel_b = m_sel;
      m_upd = 1'b0;
      if ((enc_cw ^ enc_ccw) && st_b == 0 && db_b) begin
        v = m_val[sel_b] + (enc_cw ? stepv(sel_b) : -stepv(sel_b));
        if (v < 0) v = 0;
        if (v > maxv(sel_b)) v = maxv(sel_b);
        if (v != m_val[sel_b]) begin
          m_val[sel_b] = v; m_upd = 1'b1; m_addr = sel_b;
        end
      end
      case (st_b)
        0: if (armed_b && !db_b) begin m_state = 1; m_start = m_n; end
        1: begin
          if (db_b) begin
            m_sel = (sel_b + 1) % 3; m_state = 0;
          end else if (m_n - m_start == LONG) begin
            m_val[sel_b] = defv(sel_b); m_upd = 1'b1; m_addr = sel_b; m_state = 2;
          end
        end
        default: if (db_b) m_state = 0;
      endcase
      // synced sample at edge n is the raw sample from edge n-2
      all_diff = 1'b1;
      for (int k = 2; k <= DEB + 1; k++)
        if (hist[hist.size() - 1 - k] == m_db) all_diff = 1'b0;
      if (all_diff) m_db = ~m_db;
      if (m_n >= 3 && hist[hist.size() - 3] == 1'b1 && db_b) m_armed = 1'b1;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic compare_cycle();
    if (sys_rst) return;
    chk("sel", 32'(sel), 32'(m_sel));
    chk("tb_idx", 32'(tb_idx), 32'(m_val[0]));
    chk("vg_idx", 32'(vg_idx), 32'(m_val[1]));
    chk("trig_lvl", 32'(trig_lvl), 32'(m_val[2]));
    chk("cfg_update", 32'(cfg_update), 32'(m_upd));
    if (m_upd) chk("cfg_addr", 32'(cfg_addr), 32'(m_addr));
    if (cfg_update) begin
      upd_total++;
      last_addr = int'(cfg_addr);
    end
  endtask

  task automatic step(input logic cw, input logic ccw, input logic sw);
    enc_cw = cw; enc_ccw = ccw; enc_sw = sw;
    @(posedge sys_clk);
    @(negedge sys_clk);
    compare_cycle();
  endtask

  task automatic idle(input int k, input logic sw);
    for (int i = 0; i < k; i++) step(1'b0, 1'b0, sw);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rst_sel", 32'(sel), 0);
    chk("rst_tb_idx", 32'(tb_idx), 8);
    chk("rst_vg_idx", 32'(vg_idx), 3);
    chk("rst_trig_lvl", 32'(trig_lvl), 128);
    chk("rst_cfg_update", 32'(cfg_update), 0);
    chk("rst_cfg_addr", 32'(cfg_addr), 0);
    idle(5, 1'b1);

    // timebase saturation with back-to-back pulses
    base = upd_total;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i == 7) chk("tb_at_pulse7", 32'(tb_idx), 15);
    end
    idle(2, 1'b1);
    chk("tb_upd_count", 32'(upd_total - base), 7);

    // bouncy short press, then vgain down to zero
    base = upd_total;
    step(1'b0, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b1);
    idle(10, 1'b0);
    step(1'b0, 1'b0, 1'b1); step(1'b0, 1'b0, 1'b0);
    idle(12, 1'b1);
    chk("short_sel", 32'(sel), 1);
    chk("short_no_upd", 32'(upd_total - base), 0);
    base = upd_total;
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b1, 1'b1);
      if (i == 3) chk("vg_at_pulse3", 32'(vg_idx), 0);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("vg_upd_count", 32'(upd_total - base), 3);
    chk("vg_addr", 32'(last_addr), 1);

    // trigger level saturation then long press
    idle(8, 1'b0); idle(10, 1'b1);
    chk("sel_tl", 32'(sel), 2);
    base = upd_total;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (i == 31) chk("tl_at_pulse31", 32'(trig_lvl), 252);
      if (i == 32) chk("tl_at_pulse32", 32'(trig_lvl), 255);
    end
    idle(2, 1'b1);
    chk("tl_upd_count", 32'(upd_total - base), 32);
    base = upd_total;
    idle(30, 1'b0); idle(10, 1'b1);
    chk("long_tl_default", 32'(trig_lvl), 128);
    chk("long_upd_count", 32'(upd_total - base), 1);
    chk("long_addr", 32'(last_addr), 2);
    chk("long_sel_kept", 32'(sel), 2);

    // simultaneous pulses and rotation while pressed
    base = upd_total;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    idle(8, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
    idle(1, 1'b0); idle(10, 1'b1);
    chk("ign_tl", 32'(trig_lvl), 128);
    chk("ign_sel_wrap", 32'(sel), 0);
    chk("ign_upd_count", 32'(upd_total - base), 0);

    // rotation while held after a long press on timebase
    base = upd_total;
    idle(30, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    idle(4, 1'b0); idle(10, 1'b1);
    chk("held_tb_default", 32'(tb_idx), 8);
    chk("held_upd_count", 32'(upd_total - base), 1);
    chk("held_addr", 32'(last_addr), 0);

    // reset in the middle of a press
    idle(12, 1'b0);
    sys_rst = 1'b1;
    idle(2, 1'b0);
    sys_rst = 1'b0;
    base = upd_total;
    idle(10, 1'b0); idle(12, 1'b1);
    chk("rstpress_sel", 32'(sel), 0);
    chk("rstpress_upd_count", 32'(upd_total - base), 0);
    chk("rstpress_vg", 32'(vg_idx), 3);

    // a fresh press after the re-arm still works
    idle(8, 1'b0); idle(12, 1'b1);
    chk("rearm_sel", 32'(sel), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
